mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multicycle signed multiply/divide datapath for MULT/DIV. It sits directly downstream of the control unit.
//  The control unit decodes the instruction, pulses start with op, and stalls in a wait state until done.
//  Results land in internal HI/LO registers, which are read through hi/lo (MFHI/MFLO path).
//  Multiply is radix-2 Booth. Divide is restoring on magnitudes with final sign fix-up.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO are WIDTH bits each
// PORTS
//  clk       in   1      single system clock, rising edge
//  reset     in   1      synchronous, active-low reset
//  start     in   1      request; sampled only in IDLE
//  op        in   1      0 = MULT, 1 = DIV; sampled with start
//  a         in   WIDTH  multiplicand / dividend (signed); sampled with start
//  b         in   WIDTH  multiplier / divisor (signed); sampled with start
//  busy      out  1      high from the cycle after start is accepted until done
//  done      out  1      one-cycle pulse; hi/lo are valid in the same cycle
//  div_zero  out  1      set with done when DIV has b==0; cleared on next accepted start
//  hi        out  WIDTH  HI register (product high half / remainder)
//  lo        out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0.
//   - Overrides any operation in flight. Partial results are discarded.
//  States: IDLE, MULT, DIV, FIX, FIN.
//  IDLE:
//   - start=1, op=0: latch a, b. Clear the 6-bit counter. Go to MULT.
//   - start=1, op=1, b!=0: latch operands. Go to DIV.
//   - start=1, op=1, b==0: go to FIN with div_zero pending. hi/lo are left unchanged.
//  MULT: one Booth step per cycle on {acc, q, q-1}.
//   - Each step: add/sub b, then arithmetic shift right.
//   - After WIDTH steps go to FIN. {hi,lo} = full 2*WIDTH signed product, no overflow.
//  DIV: one restoring step per cycle on |a|, |b|. After WIDTH steps go to FIX.
//  FIX: apply signs.
//   - Quotient is negated if sign(a)^sign(b). It truncates toward zero.
//   - Remainder takes the sign of a.
//   - |x| of the most negative value is taken as an unsigned WIDTH-bit magnitude, so no error is raised.
//   - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps).
//  FIN:
//   - Write hi/lo (except for div-by-zero). Assert done=1 and div_zero as applicable.
//   - busy drops in the same cycle. Next state IDLE.
//  Latency, counting the start-accept edge as cycle 0 (done high during cycle N):
//   - MULT: N = WIDTH+1 (33).
//   - DIV: N = WIDTH+2 (34).
//   - DIV by zero: N = 1.
//  start while busy or in FIN is ignored, with no queuing. Operand changes while busy have no effect.
//  hi/lo hold their previous values for the whole operation. They change only at the FIN edge.
//  Back-to-back: start may be asserted in the cycle done=1. It is sampled in IDLE on the following edge.
//  The counter is never observable. It saturates and must never wrap into a second pass.
// TESTING
//  - MULT a=7, b=0xFFFFFFFD (-3) -> done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..32.
//  - MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
//  - DIV a=0xFFFFFFF9 (-7), b=2 -> done at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
//  - DIV a=5, b=0 after the MULT above -> done at cycle 1, div_zero=1, hi/lo keep 0xFFFFFFFF/0xFFFFFFEB.
//  - Second start at cycle 10 of a MULT -> ignored.
//  - Reset low at cycle 15 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit feeding HI/LO.
// Multiply: radix-2 Booth, one step per cycle. Divide: restoring on
// magnitudes, then a single sign fix-up cycle. hi/lo update only when
// the result is committed, so reads stay stable during an operation.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CMAX = '1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MULT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  // acc is one bit wider than an operand so Booth add/sub of the most
  // negative multiplier cannot overflow; in DIV it holds the remainder.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;      // multiplier / dividend-then-quotient
  logic             q1;     // Booth q(-1)
  logic [WIDTH-1:0] bval;   // multiplicand / divisor magnitude
  logic             sgn_a, sgn_b;

  logic [WIDTH:0]   b_ext, booth_sum, div_trial;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [CW-1:0]    cnt_inc;
  logic             last_step;

  // Datapath arithmetic for the current step
  always_comb begin
    b_ext = {bval[WIDTH-1], bval};
    case ({q[0], q1})
      2'b01:   booth_sum = acc + b_ext;
      2'b10:   booth_sum = acc - b_ext;
      default: booth_sum = acc;
    endcase
    div_trial = {acc[WIDTH-1:0], q[WIDTH-1]} - {1'b0, bval};
    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    a_mag     = a[WIDTH-1] ? -a : a;
    b_mag     = b[WIDTH-1] ? -b : b;
    quo_fix   = (sgn_a ^ sgn_b) ? -q : q;
    rem_fix   = sgn_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    cnt_inc   = (cnt == CMAX) ? cnt : cnt + 1'b1;
    last_step = (cnt == LAST);
  end

  assign busy = (state == S_MULT) || (state == S_DIV) || (state == S_FIX);
  assign done = (state == S_FIN);

  // Control FSM, iteration registers and HI/LO commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      q1       <= 1'b0;
      bval     <= '0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt      <= '0;
          div_zero <= 1'b0;
          acc      <= '0;
          q1       <= 1'b0;
          if (!op) begin
            q     <= a;
            bval  <= b;
            state <= S_MULT;
          end else if (b == '0) begin
            div_zero <= 1'b1;
            state    <= S_FIN;
          end else begin
            q     <= a_mag;
            bval  <= b_mag;
            sgn_a <= a[WIDTH-1];
            sgn_b <= b[WIDTH-1];
            state <= S_DIV;
          end
        end
        S_MULT: begin
          // add/sub then arithmetic shift right of {acc, q, q1}
          acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          q   <= {booth_sum[0], q[WIDTH-1:1]};
          q1  <= q[0];
          cnt <= cnt_inc;
          if (last_step) begin
            hi    <= booth_sum[WIDTH:1];
            lo    <= {booth_sum[0], q[WIDTH-1:1]};
            state <= S_FIN;
          end
        end
        S_DIV: begin
          if (div_trial[WIDTH]) begin
            acc <= {acc[WIDTH-1:0], q[WIDTH-1]};
            q   <= {q[WIDTH-2:0], 1'b0};
          end else begin
            acc <= div_trial;
            q   <= {q[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt_inc;
          if (last_step) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= rem_fix;
          lo    <= quo_fix;
          state <= S_FIN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, ignored start,
// divide-by-zero, back-to-back start and mid-operation reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation, optionally poke a second start at cycle inj,
  // and return positioned inside the done cycle.
  task automatic run_op(input string tag, input logic o, input logic [31:0] va,
                        input logic [31:0] vb, input int exp_cyc, input int inj,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz);
    int cyc;
    logic busy_ok;
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = o; a = va; b = vb;
    if (done) tick();            // FIN -> IDLE edge; start sampled on the next one
    tick();                      // accept edge = cycle 0
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (cyc == inj) begin
        check({tag, "_hold_hi"}, hi, hi0);
        check({tag, "_hold_lo"}, lo, lo0);
        start = 1'b1; op = 1'b1; a = 32'd1; b = 32'd1;
      end
      tick();
      if (cyc == inj) start = 1'b0;
      cyc++;
    end
    check({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    // 7 * -3 = -21; second start at cycle 10 must be ignored
    run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 33, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    tick();
    check("mul_7_m3_done_pulse", {31'd0, done}, 32'd0);
    check("mul_7_m3_no_requeue", {31'd0, busy}, 32'd0);

    // divide by zero: done at cycle 1, hi/lo untouched
    run_op("div_by0", 1'b1, 32'd5, 32'd0, 1, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);

    // back-to-back from the done cycle; div_zero clears on accept
    run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 33, 0,
           32'h4000_0000, 32'h0000_0000, 1'b0);
    tick();

    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    tick();

    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0,
           32'h0000_0000, 32'h8000_0000, 1'b0);
    tick();

    // 100 / -7 = -14 rem 2
    run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 34, 0,
           32'h0000_0002, 32'hFFFF_FFF2, 1'b0);
    tick();

    // -1 * -1 = 1
    run_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0,
           32'h0000_0000, 32'h0000_0001, 1'b0);
    tick();

    // reset at cycle 15 of a DIV
    begin
      logic saw_done;
      start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
      tick();
      start = 1'b0;
      for (int i = 1; i < 15; i++) tick();
      check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      tick();
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      reset = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (done) saw_done = 1'b1;
        tick();
      end
      check("rst_mid_no_done", {31'd0, saw_done}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
